udp_port_arbiter: RTL
=====================

// Module: udp_port_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter sharing one UDP calc engine (sum/max) among N_PORTS ingress streams.
//  Locks a granted port for a whole fixed-length packet, tags each grant in order, and routes each returned
//  32-bit engine result to the requester that sent the packet. Sits between the ingress ports and the engine.
// PARAMETERS
//  N_PORTS    4    number of requesting ports (>=2)
//  DATA_W     256  beat width, ingress and engine
//  RES_W      32   result width, taken from engine result bits [RES_W-1:0]
//  PKT_BEATS  63   beats per packet (fixed; beat 1 carries opcode, passed through untouched)
//  TAG_DEPTH  4    max packets granted but not yet answered (power of 2)
// PORTS
//  clk            in   1                 clock
//  reset          in   1                 synchronous, active-low reset
//  req_data       in   N_PORTS*DATA_W    port p beat at [p*DATA_W +: DATA_W]
//  req_valid      in   N_PORTS           per-port beat valid
//  req_ready      out  N_PORTS           per-port beat ready
//  eng_data       out  DATA_W            beat to engine
//  eng_valid      out  1                 beat valid to engine
//  eng_ready      in   1                 engine accepts beat
//  eng_res_data   in   DATA_W            engine result bus; only [RES_W-1:0] used
//  eng_res_valid  in   1                 engine result valid
//  eng_res_ready  out  1                 arbiter accepts result
//  res_data       out  RES_W             result to owning port (shared bus)
//  res_valid      out  N_PORTS           one-hot result valid
//  res_ready      in   N_PORTS           per-port result ready
//  grant_id       out  $clog2(N_PORTS)   port currently/last granted
//  busy           out  1                 1 while in XFER
//  err_orphan     out  1                 sticky: result arrived with tag queue empty
// BEHAVIOUR
//  Reset: state IDLE, beat_cnt 0, tag queue empty, last_grant N_PORTS-1 (port 0 highest priority),
//   grant_id 0, err_orphan 0; all outputs 0 (req_ready, eng_valid, eng_res_ready, res_valid, busy).
//  FSM (arb_state_t): IDLE -> XFER -> IDLE.
//   IDLE: if any req_valid and tag queue not full, pick first valid port scanning last_grant+1 upward
//    with wrap; register grant_id, push grant_id into tag queue, go XFER. No beats pass in IDLE
//    (1 cycle bubble between packets). Queue full -> stay IDLE, no grant.
//   XFER: eng_data = req_data[grant_id], eng_valid = req_valid[grant_id], req_ready[grant_id] = eng_ready,
//    all other req_ready 0 (combinational passthrough, zero added latency). beat_cnt increments on
//    eng_valid&&eng_ready; handshake with beat_cnt==PKT_BEATS-1 -> beat_cnt<=0, last_grant<=grant_id, IDLE.
//   Granted port deasserting valid mid-packet: lock held, no timeout, no reorder.
//  Result path (independent of FSM): head = tag queue front.
//   res_valid[head] = eng_res_valid && !empty; res_data = eng_res_data[RES_W-1:0];
//   eng_res_ready = !empty && res_ready[head]; pop on eng_res_valid&&eng_res_ready.
//   Empty queue with eng_res_valid: eng_res_ready 0, err_orphan<=1 (cleared only by reset).
//  Simultaneous push (grant) and pop: occupancy unchanged, both take effect.
//  beat_cnt width $clog2(PKT_BEATS); never exceeds PKT_BEATS-1.
//  Reset mid-packet: abort, discard queued tags; engine must be reset together with this block.
// STRUCTURE
//  udp_pkg: arb_state_t {IDLE, XFER}, PKT_BEATS, DATA_W, RES_W defaults.
//  Sub-module udp_tag_fifo: sync FIFO, width $clog2(N_PORTS), depth TAG_DEPTH, push/pop/full/empty/head.
//  Top holds FSM, RR pointer, beat counter, data/ready muxes, result demux.
// TESTING
//  Port 0 only, 63 beats, eng_ready=1 -> 63 beats on eng_data in order, busy high 63 cycles, back to IDLE.
//  Ports 0,2 valid, last_grant=3 -> grant 0 then 2; port 0 re-requesting waits until 2 finishes.
//  All 4 ports valid, results delayed 200 cycles, TAG_DEPTH=4 -> 4 grants then stall in IDLE until 1st pop.
//  Results 0xA,0xB for grants (1,3), res_ready[1]=0 for 5 cycles -> 0xA held on port 1, 0xB waits behind it.
//  eng_res_valid=1 with empty queue -> eng_res_ready=0, err_orphan=1 and sticky.
//  reset=0 at beat 30 of port 2 -> next cycle all outputs 0, queue empty, port 0 wins next grant.

Source files
------------

// File: rtl/udp_pkg.sv
// Shared types and default sizes for the UDP port arbiter slice.
package udp_pkg;

  localparam int DATA_W_DEF    = 256;
  localparam int RES_W_DEF     = 32;
  localparam int PKT_BEATS_DEF = 63;

  typedef enum logic {
    IDLE,
    XFER
  } arb_state_t;

endpackage

// File: rtl/udp_tag_fifo.sv
// Synchronous tag FIFO: remembers, in grant order, which port owns each in-flight packet.
module udp_tag_fifo
  import udp_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer distinguishes full from empty.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/udp_port_arbiter.sv
// Packet-granular round-robin arbiter in front of a shared UDP calc engine, with in-order result routing.
module udp_port_arbiter
  import udp_pkg::*;
#(
  parameter int N_PORTS   = 4,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RES_W     = RES_W_DEF,
  parameter int PKT_BEATS = PKT_BEATS_DEF,
  parameter int TAG_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_PORTS*DATA_W-1:0]   req_data,
  input  logic [N_PORTS-1:0]          req_valid,
  output logic [N_PORTS-1:0]          req_ready,
  output logic [DATA_W-1:0]           eng_data,
  output logic                        eng_valid,
  input  logic                        eng_ready,
  input  logic [DATA_W-1:0]           eng_res_data,
  input  logic                        eng_res_valid,
  output logic                        eng_res_ready,
  output logic [RES_W-1:0]            res_data,
  output logic [N_PORTS-1:0]          res_valid,
  input  logic [N_PORTS-1:0]          res_ready,
  output logic [$clog2(N_PORTS)-1:0]  grant_id,
  output logic                        busy,
  output logic                        err_orphan
);

  localparam int GW = $clog2(N_PORTS);
  localparam int BW = $clog2(PKT_BEATS);

  arb_state_t    state;
  logic [GW-1:0] last_grant;
  logic [BW-1:0] beat_cnt;

  logic [GW-1:0] pick;
  logic          pick_ok;
  logic          tag_full;
  logic          tag_empty;
  logic [GW-1:0] tag_head;
  logic          grant_go;
  logic          beat_fire;
  logic          res_pop;

  // Only the low RES_W bits of the engine result bus carry the answer.
  logic unused_res_bits;
  assign unused_res_bits = ^eng_res_data[DATA_W-1:RES_W];

  // Round-robin scan starting just after the last port served.
  always_comb begin
    // NOTE: every always_comb output gets a default up front so no path leaves it unassigned (no latch).
    pick    = '0;
    pick_ok = 1'b0;
    for (int i = 1; i <= N_PORTS; i++) begin
      int idx;
      idx = (int'(last_grant) + i) % N_PORTS;
      if (!pick_ok && req_valid[idx]) begin
        pick_ok = 1'b1;
        pick    = GW'(idx);
      end
    end
  end

  assign grant_go  = (state == IDLE) && pick_ok && !tag_full;
  assign beat_fire = eng_valid && eng_ready;
  assign res_pop   = eng_res_valid && eng_res_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= GW'(N_PORTS-1);
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_go) begin
            grant_id <= pick;
            state    <= XFER;
          end
        end
        XFER: begin
          if (beat_fire) begin
            if (beat_cnt == BW'(PKT_BEATS-1)) begin
              beat_cnt   <= '0;
              last_grant <= grant_id;
              state      <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      err_orphan <= 1'b0;
    else if (eng_res_valid && tag_empty)
      err_orphan <= 1'b1;
  end

  assign busy      = (state == XFER);
  assign eng_valid = busy && req_valid[grant_id];
  assign eng_data  = busy ? req_data[grant_id*DATA_W +: DATA_W] : '0;

  always_comb begin
    req_ready = '0;
    if (busy)
      req_ready[grant_id] = eng_ready;
  end

  always_comb begin
    res_valid = '0;
    if (eng_res_valid && !tag_empty)
      res_valid[tag_head] = 1'b1;
  end

  assign res_data      = eng_res_data[RES_W-1:0];
  assign eng_res_ready = !tag_empty && res_ready[tag_head];

  udp_tag_fifo #(
    .W     (GW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (grant_go),
    .push_data (pick),
    .pop       (res_pop),
    .full      (tag_full),
    .empty     (tag_empty),
    .head      (tag_head)
  );

endmodule
